// File: rtl/multicore_pkg.sv
// Shared constants and types for the core.
// This package also holds the write-port arbiter's result type and default sizes.
package multicore_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_SIZE  = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  // Default sizing for the long-latency write-port queue.
  localparam int WPORT_FIFO_DEPTH = 2;
  localparam int WPORT_MAX_WAIT   = 4;

  // One completed long-latency result waiting for the register-file port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rdest;
    logic [DATA_SIZE-1:0]  data;
  } lu_result_t;

  // One-hot register mask. x0 is never marked because it is never written.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = '0;
    if (r != '0) reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/wport_fifo.sv
// Small synchronous FIFO for long-latency results.
// Each slot carries its own valid bit, so the owner can OR the per-entry
// destination tags into a pending mask.
module wport_fifo
  import multicore_pkg::*;
#(
  parameter type T       = lu_result_t,
  parameter int  DEPTH   = WPORT_FIFO_DEPTH,
  parameter int  TAG_W   = REG_ADDR_W,
  parameter int  TAG_LSB = DATA_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  T                            push_data_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output T                            head_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tags_o
);

  localparam int PTR_W = $clog2(DEPTH);

  T     [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok;

  // The slot under the write pointer is still occupied when the ring is full.
  // The slot under the read pointer is free when the ring is empty.
  assign full_o  = valid_q[wr_ptr_q];
  assign empty_o = ~valid_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state slot occupancy.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
    valid_d = valid_q;
    if (pop_ok)  valid_d[rd_ptr_q] = 1'b0;
    if (push_ok) valid_d[wr_ptr_q] = 1'b1;
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; the valid bits alone decide what is meaningful.
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  // Expose the destination tag of every slot for the owner's pending mask.
  always_comb begin
    tags_o = '0;
    for (int i = 0; i < DEPTH; i++) tags_o[i] = mem_q[i][TAG_LSB +: TAG_W];
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// writeback and queued long-latency results. The pipeline always wins.
// Queued results drain into idle slots. A starved head raises a bubble request.
module regfile_wport_arbiter
  import multicore_pkg::*;
#(
  parameter int FIFO_DEPTH = WPORT_FIFO_DEPTH,
  parameter int MAX_WAIT   = WPORT_MAX_WAIT
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_rdest,
  input  logic [DATA_SIZE-1:0]  i_wb_data,
  input  logic                  i_lu_valid,
  output logic                  o_lu_ready,
  input  logic [REG_ADDR_W-1:0] i_lu_rdest,
  input  logic [DATA_SIZE-1:0]  i_lu_data,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_SIZE-1:0]  o_rf_wdata,
  output logic [NUM_REGS-1:0]   o_pending,
  output logic                  o_stall_req
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic                                 fifo_full, fifo_empty;
  logic                                 lu_push, lu_pop, slot_busy;
  lu_result_t                           lu_in, fifo_head;
  logic [FIFO_DEPTH-1:0]                fifo_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] fifo_tags;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_SIZE-1:0]  rf_wdata_q, rf_wdata_d;
  logic                  lu_inflight_q, lu_inflight_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  stall_q, stall_d;

  // A pipeline write to x0 is dropped, so it leaves the slot free for the queue.
  assign slot_busy  = i_wb_regwrite & (i_wb_rdest != '0);
  assign o_lu_ready = ~fifo_full;
  assign lu_push    = i_lu_valid & ~fifo_full;
  assign lu_pop     = ~slot_busy & ~fifo_empty;

  assign lu_in.rdest = i_lu_rdest;
  assign lu_in.data  = i_lu_data;

  wport_fifo #(
    .T       (lu_result_t),
    .DEPTH   (FIFO_DEPTH),
    .TAG_W   (REG_ADDR_W),
    .TAG_LSB (DATA_SIZE)
  ) u_fifo (
    .clk         (i_aclk),
    .rst_n       (i_areset_n),
    .push_i      (lu_push),
    .push_data_i (lu_in),
    .pop_i       (lu_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .tags_o      (fifo_tags)
  );

  // Grant the port. Address and data hold their last value when nothing is written.
  always_comb begin
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    lu_inflight_d = 1'b0;
    if (slot_busy) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = i_wb_rdest;
      rf_wdata_d = i_wb_data;
    end else if (lu_pop && (fifo_head.rdest != '0)) begin
      rf_we_d       = 1'b1;
      rf_waddr_d    = fifo_head.rdest;
      rf_wdata_d    = fifo_head.data;
      lu_inflight_d = 1'b1;
    end
  end

  // Age of the queue head. The count saturates at MAX_WAIT and restarts on every pop.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || lu_pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    stall_d = (wait_cnt_d == CNT_W'(MAX_WAIT));
  end

  // Output register, in-flight marker, wait counter and stall request.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      lu_inflight_q <= 1'b0;
      wait_cnt_q    <= '0;
      stall_q       <= 1'b0;
    end else begin
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      lu_inflight_q <= lu_inflight_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_q       <= stall_d;
    end
  end

  // Pending mask: destinations still queued, plus a queued result in the output register.
  // A result pushed on the same edge as a drain keeps its bit set through its own slot.
  always_comb begin
    o_pending = lu_inflight_q ? reg_onehot(rf_waddr_q) : '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) o_pending = o_pending | reg_onehot(fifo_tags[i]);
    end
  end

  assign o_rf_we     = rf_we_q;
  assign o_rf_waddr  = rf_waddr_q;
  assign o_rf_wdata  = rf_wdata_q;
  assign o_stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter.
// A queue-based reference model predicts every registered output one edge ahead.
module tb_regfile_wport_arbiter;
  import multicore_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  wb_regwrite = 1'b0;
  logic [REG_ADDR_W-1:0] wb_rdest = '0;
  logic [DATA_SIZE-1:0]  wb_data = '0;
  logic                  lu_valid = 1'b0;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_rdest = '0;
  logic [DATA_SIZE-1:0]  lu_data = '0;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_SIZE-1:0]  rf_wdata;
  logic [NUM_REGS-1:0]   pending;
  logic                  stall_req;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .i_aclk        (clk),
    .i_areset_n    (rst_n),
    .i_wb_regwrite (wb_regwrite),
    .i_wb_rdest    (wb_rdest),
    .i_wb_data     (wb_data),
    .i_lu_valid    (lu_valid),
    .o_lu_ready    (lu_ready),
    .i_lu_rdest    (lu_rdest),
    .i_lu_data     (lu_data),
    .o_rf_we       (rf_we),
    .o_rf_waddr    (rf_waddr),
    .o_rf_wdata    (rf_wdata),
    .o_pending     (pending),
    .o_stall_req   (stall_req)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  lu_result_t            q[$];
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [DATA_SIZE-1:0]  m_data;
  logic                  m_from_lu;
  int                    m_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REGS-1:0] model_pending();
    logic [NUM_REGS-1:0] p;
    p = '0;
    if (m_from_lu && m_addr != 0) p[m_addr] = 1'b1;
    foreach (q[i]) if (q[i].rdest != 0) p[q[i].rdest] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_from_lu = 1'b0; m_wait = 0;
  endtask

  task automatic drive(input logic wr, input int wrd, input logic [31:0] wd,
                       input logic lv, input int lrd, input logic [31:0] ld);
    wb_regwrite = wr; wb_rdest = REG_ADDR_W'(wrd); wb_data = wd;
    lu_valid = lv;    lu_rdest = REG_ADDR_W'(lrd); lu_data = ld;
  endtask

  // Advance one clock: predict from the current inputs, clock, then compare.
  task automatic cycle();
    logic busy, pop, push, was_empty;
    lu_result_t h, n;
    chk("lu_ready", 64'(lu_ready), 64'(q.size() < DEPTH));
    if (wb_regwrite && wb_rdest != 0) chk("wb_to_pending_reg", 64'(pending[wb_rdest]), 64'(0));
    push      = lu_valid && (q.size() < DEPTH);
    busy      = wb_regwrite && (wb_rdest != 0);
    was_empty = (q.size() == 0);
    pop       = !busy && !was_empty;
    m_we = 1'b0; m_from_lu = 1'b0;
    if (busy) begin
      m_we = 1'b1; m_addr = wb_rdest; m_data = wb_data;
    end else if (pop) begin
      h = q.pop_front();
      if (h.rdest != 0) begin
        m_we = 1'b1; m_addr = h.rdest; m_data = h.data; m_from_lu = 1'b1;
      end
    end
    if (push) begin
      n.rdest = lu_rdest; n.data = lu_data;
      q.push_back(n);
    end
    if (was_empty || pop) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    @(posedge clk); #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
    chk("pending", 64'(pending), 64'(model_pending()));
    chk("stall_req", 64'(stall_req), 64'(m_wait == MAXW));
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(rf_we), 64'(0));
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(0));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(0));
    chk({tag, "_pending"}, 64'(pending), 64'(0));
    chk({tag, "_stall"}, 64'(stall_req), 64'(0));
    chk({tag, "_ready"}, 64'(lu_ready), 64'(1));
  endtask

  initial begin
    logic [NUM_REGS-1:0] mp;
    int                  r;
    model_reset();

    // Reset, with a push attempted while reset is held low.
    drive(0, 0, 0, 1, 5, 32'h11);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(2);
    chk("reset_push_ignored", 64'(pending[5]), 64'(0));

    // Idle-slot drain.
    drive(0, 0, 0, 1, 7, 32'hDEAD);
    cycle();
    chk("drain_p7_set", 64'(pending[7]), 64'(1));
    idle(1);
    chk("drain_we", 64'(rf_we), 64'(1));
    chk("drain_waddr", 64'(rf_waddr), 64'(7));
    chk("drain_wdata", 64'(rf_wdata), 64'(32'hDEAD));
    idle(1);
    chk("drain_p7_clear", 64'(pending[7]), 64'(0));

    // Priority: pipeline writes go first, then the queued r9 uses the first idle slot.
    drive(1, 3, 1, 1, 9, 32'h99); cycle();
    drive(1, 4, 2, 0, 0, 0);      cycle();
    drive(1, 6, 3, 0, 0, 0);      cycle();
    chk("prio_r6", 64'(rf_waddr), 64'(6));
    idle(1);
    chk("prio_r9_addr", 64'(rf_waddr), 64'(9));
    chk("prio_r9_data", 64'(rf_wdata), 64'(32'h99));
    idle(2);

    // Starvation: one entry queued behind a continuously busy pipeline.
    drive(1, 10, 32'hA0, 1, 12, 32'hABC); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 13 + (i % 3), 32'hB0 + i, 0, 0, 0);
      cycle();
      chk("starve_stall", 64'(stall_req), 64'(i >= 3));
    end
    idle(1);
    chk("starve_head_written", 64'(rf_waddr), 64'(12));
    chk("starve_stall_fell", 64'(stall_req), 64'(0));
    idle(2);

    // Full FIFO, no bypass, a queued x0 entry, and a pipeline x0 write.
    drive(1, 1, 32'h1, 1, 20, 32'hA); cycle();
    drive(1, 2, 32'h2, 1, 0, 32'hB);  cycle();
    drive(1, 3, 32'h3, 1, 21, 32'hC); cycle();
    chk("full_ready_low", 64'(lu_ready), 64'(0));
    cycle();
    drive(0, 0, 0, 1, 21, 32'hC);     cycle();
    drive(1, 0, 32'h5, 1, 21, 32'hC); cycle();
    chk("x0_entry_no_write", 64'(rf_we), 64'(0));
    idle(3);

    // Random traffic that still obeys the hazard-unit contract.
    for (int i = 0; i < 400; i++) begin
      mp = model_pending();
      r  = int'($urandom_range(0, NUM_REGS - 1));
      if (mp[r]) r = 0;
      drive(($urandom % 3) != 0, r, $urandom, ($urandom % 2) != 0,
            int'($urandom_range(0, NUM_REGS - 1)), $urandom);
      cycle();
    end
    idle(4);

    // Reset while two entries are queued and the stall request is active.
    drive(1, 1, 32'h1, 1, 22, 32'h22); cycle();
    drive(1, 2, 32'h2, 1, 23, 32'h23); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 3 + i, 32'h30 + i, 0, 0, 0);
      cycle();
    end
    chk("pre_reset_stall", 64'(stall_req), 64'(1));
    chk("pre_reset_full", 64'(lu_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback result (regwrite, rdest, wb_result);
  - a long-latency unit (multiply/divide, late loads) that completes out of band.
- The pipeline always has priority. Long-latency results queue in a small FIFO and drain into idle writeback slots.
- A starvation counter asks the hazard unit to insert a bubble when a queued result has waited too long.
- A pending-register mask lets the hazard unit stall consumers and WAW producers of queued destinations.

Parameters:
- NUM_REGS, 32, number of architectural registers; taken from multicore_pkg.
- DATA_SIZE, 32, register data width; taken from multicore_pkg.
- FIFO_DEPTH, 2, long-latency result queue entries (power of 2, >=2).
- MAX_WAIT, 4, cycles the FIFO head may be denied before o_stall_req asserts (>=1).

Ports:
- i_aclk  in  1  system clock
- i_areset_n  in  1  asynchronous active-low reset
- i_wb_regwrite  in  1  pipeline writeback wants the port this cycle
- i_wb_rdest  in  $clog2(NUM_REGS)  pipeline destination register
- i_wb_data  in  DATA_SIZE  pipeline writeback data
- i_lu_valid  in  1  long-latency result valid
- o_lu_ready  out  1  FIFO can accept a result
- i_lu_rdest  in  $clog2(NUM_REGS)  long-latency destination register
- i_lu_data  in  DATA_SIZE  long-latency result data
- o_rf_we  out  1  register-file write enable (registered)
- o_rf_waddr  out  $clog2(NUM_REGS)  register-file write address (registered)
- o_rf_wdata  out  DATA_SIZE  register-file write data (registered)
- o_pending  out  NUM_REGS  one bit per register with an outstanding long-latency write
- o_stall_req  out  1  request to the hazard unit to bubble the writeback slot

Behaviour:
- Clock is i_aclk. Reset is i_areset_n, asynchronous and active-low.
- Reset values: o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_pending=0, o_stall_req=0; FIFO empty; wait counter=0.
- o_lu_ready = !full, combinational. Pushes are ignored while reset is asserted.
- Push occurs on i_lu_valid & o_lu_ready. There is no bypass: when the FIFO is full, a same-cycle pop does not free space for a push.
- Pipeline slot is "busy" when i_wb_regwrite=1 and i_wb_rdest!=0.
- Grant, evaluated each cycle:
  - Slot busy: the pipeline owns the port. On the next edge o_rf_we=1, waddr=i_wb_rdest, wdata=i_wb_data.
  - Slot not busy and FIFO non-empty: pop the head.
    - Head rdest!=0: next edge o_rf_we=1 with the head's address and data.
    - Head rdest==0: next edge o_rf_we=0; the entry is discarded.
  - Otherwise: next edge o_rf_we=0.
- A pipeline write to x0 is dropped and counts as an idle slot.
- Latency: any granted write appears on the o_rf_* outputs exactly 1 cycle after grant.
- Wait counter:
  - Clears on every pop and while the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Saturates at MAX_WAIT.
- o_stall_req is registered. It is 1 while counter==MAX_WAIT and falls on the edge after the head pops.
- o_pending:
  - Set bit i_lu_rdest on push (rdest!=0).
  - Clear the popped head's bit on the edge o_rf_we writes it, unless another valid FIFO entry still targets that register. The bit is the OR over valid entries plus the in-flight output-register write.
  - A push and a clear of the same bit in the same cycle leave the bit set.
- Pipeline contract: the hazard unit never issues i_wb_regwrite to a register whose o_pending bit is set. The bench asserts this; no WAW reordering is attempted in RTL.
- Reset mid-operation discards all queued entries, clears o_pending, and drops any in-flight o_rf_* write.

Decomposition:
- multicore_pkg additions:
  - constant REG_ADDR_W = $clog2(NUM_REGS);
  - typedef lu_result_t = packed struct {rdest, data};
  - default FIFO_DEPTH and MAX_WAIT constants.
- One sub-module, wport_fifo: synchronous FIFO with async active-low reset, parameterised on lu_result_t and depth. It exposes push, pop, full, empty, head, and a per-entry valid vector for the pending-mask OR.

Test Plan:
- Reset: release reset with the FIFO idle -> all outputs 0 and o_lu_ready=1. Push r5=0x11 while reset is low -> ignored.
- Idle-slot drain: i_wb_regwrite=0; push r7=0xDEAD -> next cycle o_pending[7]=1 and grant; following edge o_rf_we=1, waddr=7, wdata=0xDEAD; o_pending[7]=0 after that write.
- Priority: pipeline writes r3=1, r4=2, r6=3 back-to-back while LU pushes r9=0x99 -> outputs show r3, r4, r6, then r9 in the first idle cycle.
- Starvation (MAX_WAIT=4): continuous pipeline writes with one entry queued -> o_stall_req rises 4 cycles after the push. Deasserting i_wb_regwrite for 1 cycle -> head written; o_stall_req falls the next edge.
- Full and x0 handling: FIFO_DEPTH=2 with 2 entries and the pipeline busy -> o_lu_ready=0 and a third valid is held until the slot frees. Queued rdest=0 pops with o_rf_we=0. A pipeline write to x0 lets the head drain.
- Mid-operation reset: reset with 2 entries queued and o_stall_req=1 -> FIFO empty, o_pending=0, o_stall_req=0, o_rf_we=0 immediately.
